// File: rtl/cpu_pkg.sv
// Shared CPU board constants: front-panel mode encodings, also used by the
// LED and seven-segment display logic.
package cpu_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_STEP = 2'd2,
        MODE_HALT = 2'd3
    } mode_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: polarity normalize, 2-flop synchronizer, counting
// debouncer and a single-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          btn_n;
    logic          sync1;
    logic          sync2;
    logic          level;
    logic          armed;
    logic [1:0]    primed;
    logic [CW-1:0] cnt;

    assign btn_n = BTN_ACTIVE_LOW ? ~btn : btn;

    // A button already held when reset releases must not count as a press:
    // pulses are only enabled once a genuine released level has been seen
    // through the primed synchronizer.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // which is what makes sync1 -> sync2 a real two-stage synchronizer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            armed  <= 1'b0;
            primed <= 2'b00;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1  <= btn_n;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            press  <= 1'b0;
            if (primed[1] && !sync2 && !level) begin
                armed <= 1'b1;
            end
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2 & armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_front_panel.sv
// Run/step/stop front panel for the cpu top level: debounced buttons feed a
// 4-state Moore machine whose registered state drives run, stop and mode.
module cpu_front_panel
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_CYCLES     = 8,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run_btn,
    input  logic       stop_btn,
    input  logic       step_btn,
    input  logic       halt_in,
    output logic       run,
    output logic       stop,
    output logic [1:0] mode
);

    localparam int SW = $clog2(STEP_CYCLES + 1);

    logic          run_p;
    logic          stop_p;
    logic          step_p;
    mode_t         state;
    mode_t         next_state;
    logic [SW-1:0] step_cnt;
    logic          step_done;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_run_btn (
        .clock(clock),
        .reset(reset),
        .btn  (run_btn),
        .press(run_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_stop_btn (
        .clock(clock),
        .reset(reset),
        .btn  (stop_btn),
        .press(stop_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_step_btn (
        .clock(clock),
        .reset(reset),
        .btn  (step_btn),
        .press(step_p)
    );

    // The last STEP cycle is the one holding count 1, giving STEP_CYCLES
    // cycles of run per step.
    assign step_done = (step_cnt == SW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= MODE_IDLE;
            step_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state == MODE_STEP && state != MODE_STEP) begin
                step_cnt <= SW'(STEP_CYCLES);
            end else if (state == MODE_STEP && step_cnt != '0) begin
                step_cnt <= step_cnt - 1'b1;
            end
        end
    end

    // NOTE: next_state is defaulted before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            MODE_IDLE: begin
                if (stop_p)      next_state = MODE_HALT;
                else if (step_p) next_state = MODE_STEP;
                else if (run_p)  next_state = MODE_RUN;
            end
            MODE_RUN: begin
                if (stop_p || halt_in) next_state = MODE_HALT;
            end
            MODE_STEP: begin
                if (stop_p || halt_in || step_done) next_state = MODE_HALT;
            end
            MODE_HALT: begin
                if (step_p)     next_state = MODE_STEP;
                else if (run_p) next_state = MODE_RUN;
            end
            default: next_state = MODE_IDLE;
        endcase
    end

    assign run  = (state == MODE_RUN) || (state == MODE_STEP);
    assign stop = (state == MODE_HALT);
    assign mode = state;

endmodule

// File: tb/tb_cpu_front_panel.sv
// Directed bench for cpu_front_panel: button latency, bounce rejection, step
// length, halt/stop handling, simultaneous presses and async reset.
module tb_cpu_front_panel;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run_btn = 1'b1;
    logic       stop_btn = 1'b1;
    logic       step_btn = 1'b1;
    logic       halt_in = 1'b0;
    logic       run;
    logic       stop;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_front_panel dut (
        .clock   (clock),
        .reset   (reset),
        .run_btn (run_btn),
        .stop_btn(stop_btn),
        .step_btn(step_btn),
        .halt_in (halt_in),
        .run     (run),
        .stop    (stop),
        .mode    (mode)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Counts rising edges from now until run is seen high (bounded).
    task automatic wait_for_run(input string tag, input int budget, output int edges);
        edges = 0;
        while (run !== 1'b1 && edges < budget) begin
            @(negedge clock);
            edges++;
        end
        check(tag, run, 1);
    endtask

    // Counts consecutive cycles with run high, starting at the current one.
    task automatic count_run(input int budget, output int n);
        n = 0;
        while (run === 1'b1 && n < budget) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        int edges;
        int n;
        int bad_cycles;
        int run_seen;

        // Reset state, both while held and after release
        #12;
        check("rst_run", run, 0);
        check("rst_stop", stop, 0);
        check("rst_mode", mode, 0);
        @(negedge clock);
        reset = 1'b1;
        cycles(5);
        check("idle_run", run, 0);
        check("idle_mode", mode, 0);

        // Run press: 2 sync + 16 debounce + 1 state edge, held 40 cycles
        run_btn = 1'b0;
        wait_for_run("run_rise", 40, edges);
        check("run_latency", edges, 19);
        check("run_mode", mode, 1);
        bad_cycles = 0;
        for (int i = edges; i < 40; i++) begin
            @(negedge clock);
            if (mode !== 2'd1) bad_cycles++;
        end
        run_btn = 1'b1;
        cycles(30);
        check("run_hold_stable", bad_cycles, 0);
        check("run_after_release", mode, 1);

        // One-cycle halt_in in RUN
        halt_in = 1'b1;
        @(negedge clock);
        halt_in = 1'b0;
        check("halt_run", run, 0);
        check("halt_stop", stop, 1);
        check("halt_mode", mode, 3);

        // HALT -> RUN with run button
        run_btn = 1'b0;
        wait_for_run("rerun_rise", 40, edges);
        check("rerun_latency", edges, 19);
        check("rerun_mode", mode, 1);
        run_btn = 1'b1;
        cycles(25);

        // Stop button from RUN
        stop_btn = 1'b0;
        edges = 0;
        while (stop !== 1'b1 && edges < 40) begin
            @(negedge clock);
            edges++;
        end
        check("stop_latency", edges, 19);
        check("stop_mode", mode, 3);
        check("stop_run", run, 0);
        stop_btn = 1'b1;
        cycles(25);

        // Bounce train on step: runs of 3 samples never settle
        for (int i = 0; i < 10; i++) begin
            step_btn = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clock);
        end
        check("bounce_no_step", mode, 3);
        step_btn = 1'b0;
        wait_for_run("step_rise", 40, edges);
        check("step_mode", mode, 2);
        count_run(20, n);
        check("step_len", n, 8);
        check("step_end_mode", mode, 3);
        check("step_end_stop", stop, 1);
        cycles(20);
        check("step_held_no_retrigger", mode, 3);
        step_btn = 1'b1;
        cycles(25);

        // Stop pressed so its pulse lands in the third STEP cycle
        step_btn = 1'b0;
        cycles(3);
        stop_btn = 1'b0;
        wait_for_run("step2_rise", 40, edges);
        count_run(20, n);
        check("step_stopped_len", n, 3);
        check("step_stopped_mode", mode, 3);
        step_btn = 1'b1;
        stop_btn = 1'b1;
        cycles(25);

        // Simultaneous run + stop from IDLE resolves to HALT
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(5);
        check("reidle_mode", mode, 0);
        run_btn  = 1'b0;
        stop_btn = 1'b0;
        run_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (run === 1'b1) run_seen++;
        end
        check("both_run_never", run_seen, 0);
        check("both_mode", mode, 3);
        run_btn  = 1'b1;
        stop_btn = 1'b1;
        cycles(25);

        // Async reset mid-RUN with run button still held
        run_btn = 1'b0;
        wait_for_run("pre_reset_rise", 40, edges);
        cycles(3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_run", run, 0);
        check("async_rst_mode", mode, 0);
        @(negedge clock);
        reset = 1'b1;
        run_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (run === 1'b1) run_seen++;
        end
        check("held_after_rst_run", run_seen, 0);
        check("held_after_rst_mode", mode, 0);
        run_btn = 1'b1;
        cycles(25);
        check("released_mode", mode, 0);
        run_btn = 1'b0;
        wait_for_run("repress_rise", 40, edges);
        check("repress_latency", edges, 19);
        check("repress_mode", mode, 1);
        run_btn = 1'b1;
        cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
